// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared widths, defaults and types for the instruction
// prefetch unit.
//   MemBusWidth / DataWidth : instruction memory bus and instruction widths
//   FetchQDepth             : default prefetch FIFO depth
//   ResetPc                 : default first fetch address after reset
//   fq_entry_t              : one buffered instruction with its PC
//   fq_state_e              : request/wait FSM encoding
package fetch_queue_pkg;

  localparam int MemBusWidth = 32;
  localparam int DataWidth   = 32;
  localparam int FetchQDepth = 4;
  localparam logic [31:0] ResetPc = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]          pc;
    logic [DataWidth-1:0] instr;
  } fq_entry_t;

  localparam int FqEntryWidth = $bits(fq_entry_t);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } fq_state_e;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// sync_fifo: generic synchronous FIFO, synchronous active-low reset.
//   clk, rst_n  : clock, synchronous active-low reset
//   flush       : empty the FIFO at the next edge (wins over push/pop)
//   push        : write push_data (ignored when full)
//   pop         : drop head entry (ignored when empty)
//   head_data   : current head entry
//   count       : number of valid entries, 0..DEPTH
//   full, empty : count==DEPTH, count==0
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch unit between the instruction memory port
// and decode. Issues sequential word fetches (one outstanding), buffers
// responses with their PCs, and flushes wrong-path state on redirect.
//   clk, rst_n                         : clock, synchronous active-low reset
//   redirect_valid, redirect_pc        : flush and restart fetch at redirect_pc&~3
//   mem_valid, mem_ready, mem_addr     : fetch request channel
//   mem_rvalid, mem_rdata              : fetch response
//   instr_valid, instr_ready           : decode channel handshake
//   instr, instr_pc                    : head instruction and its PC
// Build option: FETCH_QUEUE_BYPASS_EN forwards a response straight to decode
// when the FIFO is empty and decode is ready, saving one cycle of latency.
//
// state  | meaning
// S_REQ  | may issue a fetch at fetch_pc if a FIFO slot is free
// S_WAIT | one request outstanding; waiting for mem_rvalid
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = FetchQDepth,
  parameter logic [31:0] RESET_PC = ResetPc
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic [31:0]            mem_addr,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  input  logic                   mem_rvalid,
  input  logic [MemBusWidth-1:0] mem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [DataWidth-1:0]   instr,
  output logic [31:0]            instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  fq_state_e   state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic        drop_q, drop_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  fq_entry_t     push_entry, head_entry;
  logic          bypass;
  logic          req_ok;

  logic       unused_fifo_full;
  logic [1:0] unused_redirect_lsbs;
  assign unused_fifo_full     = fifo_full;
  assign unused_redirect_lsbs = redirect_pc[1:0];

  // Credit check: a request only goes out when its response has a slot.
  assign req_ok    = (state_q == S_REQ) && (fifo_count < DepthC) && !redirect_valid;
  assign mem_valid = rst_n && req_ok;
  assign mem_addr  = fetch_pc_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = (state_q == S_WAIT) && mem_rvalid && !drop_q && !redirect_valid &&
                  fifo_empty && instr_ready;
`else
  assign bypass = 1'b0;
`endif

  assign push_entry = '{pc: pending_pc_q, instr: mem_rdata};

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    drop_d       = drop_q;
    fifo_push    = 1'b0;
    case (state_q)
      S_REQ: begin
        if (mem_valid && mem_ready) begin
          fetch_pc_d   = fetch_pc_q + 32'd4;
          pending_pc_d = fetch_pc_q;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          // A response arriving with a redirect, or marked for drop, is wrong-path.
          fifo_push = !drop_q && !redirect_valid && !bypass;
          drop_d    = 1'b0;
          state_d   = S_REQ;
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = S_REQ;
    endcase
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      drop_q       <= drop_d;
    end
  end

  // Pop is suppressed under redirect; the flush clears the FIFO anyway.
  assign fifo_pop = !fifo_empty && instr_ready && !redirect_valid;

  sync_fifo #(
    .WIDTH (FqEntryWidth),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head_data (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    instr_valid = 1'b0;
    instr       = '0;
    instr_pc    = '0;
    if (rst_n) begin
      if (bypass) begin
        instr_valid = 1'b1;
        instr       = mem_rdata;
        instr_pc    = pending_pc_q;
      end else begin
        instr_valid = !fifo_empty;
        instr       = head_entry.instr;
        instr_pc    = head_entry.pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  fetch_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_addr       (mem_addr),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per clock cycle: inputs driven for that cycle and the outputs
  // expected in the same cycle (before the rising edge).
  typedef struct {
    bit          rst;
    bit          rd;
    logic [31:0] rpc;
    bit          mr;
    bit          rv;
    logic [31:0] rdata;
    bit          ir;
    bit          emv;
    logic [31:0] eaddr;
    bit          ca;
    bit          eiv;
    logic [31:0] ei;
    logic [31:0] epc;
    bit          cd;
  } vec_t;

  vec_t vq[$];
  int   n_vec;
  int   n_miss;

  task automatic add(input bit rst, input bit rd, input logic [31:0] rpc,
                     input bit mr, input bit rv, input logic [31:0] rdata, input bit ir,
                     input bit emv, input logic [31:0] eaddr, input bit ca,
                     input bit eiv, input logic [31:0] ei, input logic [31:0] epc,
                     input bit cd);
    vec_t v;
    v = '{rst, rd, rpc, mr, rv, rdata, ir, emv, eaddr, ca, eiv, ei, epc, cd};
    vq.push_back(v);
  endtask

  task automatic chk(input int idx, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL vec %0d %s: got %h expected %h", idx, name, act, exp);
      n_miss++;
    end
  endtask

  initial begin
    n_vec          = 0;
    n_miss         = 0;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_ready      = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = '0;
    instr_ready    = 1'b0;

    //   rst rd rpc           mr rv rdata          ir | emv eaddr        ca eiv ei             epc          cd
    // Reset, then streaming with 1-cycle responses: instr_valid two cycles after accept.
    add(0, 0, 32'h0,        1, 0, 32'h0,        1,  0, 32'h0,        0, 0, 32'h0,        32'h0,        1);
    add(0, 0, 32'h0,        1, 0, 32'h0,        1,  0, 32'h0,        0, 0, 32'h0,        32'h0,        1);
    add(1, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h0,        1, 0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        1, 1, 32'h13,       1,  0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h4,        1, 1, 32'h13,       32'h0,        1);
    add(1, 0, 32'h0,        1, 1, 32'h00100093, 1,  0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h8,        1, 1, 32'h00100093, 32'h4,        1);
    add(1, 0, 32'h0,        1, 1, 32'h00200113, 1,  0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'hC,        1, 1, 32'h00200113, 32'h8,        1);
    // Reset while waiting, then fill the FIFO with decode stalled.
    add(0, 0, 32'h0,        1, 0, 32'h0,        1,  0, 32'h0,        0, 0, 32'h0,        32'h0,        1);
    add(1, 0, 32'h0,        1, 0, 32'h0,        0,  1, 32'h0,        1, 0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        1, 1, 32'hA0A00000, 0,  0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        1, 0, 32'h0,        0,  1, 32'h4,        1, 1, 32'hA0A00000, 32'h0,        1);
    add(1, 0, 32'h0,        1, 1, 32'hA1A10001, 0,  0, 32'h0,        0, 1, 32'hA0A00000, 32'h0,        1);
    add(1, 0, 32'h0,        1, 0, 32'h0,        0,  1, 32'h8,        1, 1, 32'hA0A00000, 32'h0,        1);
    add(1, 0, 32'h0,        1, 1, 32'hA2A20002, 0,  0, 32'h0,        0, 1, 32'hA0A00000, 32'h0,        1);
    add(1, 0, 32'h0,        1, 0, 32'h0,        0,  1, 32'hC,        1, 1, 32'hA0A00000, 32'h0,        1);
    add(1, 0, 32'h0,        1, 1, 32'hA3A30003, 0,  0, 32'h0,        0, 1, 32'hA0A00000, 32'h0,        1);
    // Full: no fifth request until a pop.
    add(1, 0, 32'h0,        1, 0, 32'h0,        0,  0, 32'h10,       1, 1, 32'hA0A00000, 32'h0,        1);
    add(1, 0, 32'h0,        1, 0, 32'h0,        0,  0, 32'h10,       1, 1, 32'hA0A00000, 32'h0,        1);
    add(1, 0, 32'h0,        1, 0, 32'h0,        1,  0, 32'h10,       1, 1, 32'hA0A00000, 32'h0,        1);
    add(1, 0, 32'h0,        0, 0, 32'h0,        0,  1, 32'h10,       1, 1, 32'hA1A10001, 32'h4,        1);
    add(1, 0, 32'h0,        1, 0, 32'h0,        0,  1, 32'h10,       1, 1, 32'hA1A10001, 32'h4,        1);
    // Redirect together with mem_rvalid, 3 entries queued: nothing pushed, pop ignored.
    add(1, 1, 32'h2000,     1, 1, 32'hBADBAD00, 1,  0, 32'h0,        0, 1, 32'hA1A10001, 32'h4,        1);
    add(1, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h2000,     1, 0, 32'h0,        32'h0,        0);
    // Redirect to 0x1002 while waiting; stale response 3 cycles later is dropped.
    add(1, 1, 32'h1002,     1, 0, 32'h0,        1,  0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        1, 0, 32'h0,        1,  0, 32'h1000,     1, 0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        1, 0, 32'h0,        1,  0, 32'h1000,     1, 0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        1, 1, 32'hDEADBEEF, 1,  0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h1000,     1, 0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        1, 1, 32'h11,       1,  0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        0, 0, 32'h0,        1,  1, 32'h1004,     1, 1, 32'h11,       32'h1000,     1);
    // Back-to-back redirects: the last one wins.
    add(1, 1, 32'h3000,     1, 0, 32'h0,        1,  0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
    add(1, 1, 32'h4006,     1, 0, 32'h0,        1,  0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        0, 0, 32'h0,        1,  1, 32'h4004,     1, 0, 32'h0,        32'h0,        0);
    // Fetch PC wraps from 0xFFFFFFFC to 0.
    add(1, 1, 32'hFFFFFFFC, 0, 0, 32'h0,        1,  0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'hFFFFFFFC, 1, 0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        1, 1, 32'h77,       1,  0, 32'h0,        1, 0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        0, 0, 32'h0,        0,  1, 32'h0,        1, 1, 32'h77,       32'hFFFFFFFC, 1);
    // Two entries queued, then reset for one cycle while waiting.
    add(1, 0, 32'h0,        1, 0, 32'h0,        0,  1, 32'h0,        1, 1, 32'h77,       32'hFFFFFFFC, 1);
    add(1, 0, 32'h0,        1, 1, 32'h88,       0,  0, 32'h0,        0, 1, 32'h77,       32'hFFFFFFFC, 1);
    add(1, 0, 32'h0,        1, 0, 32'h0,        0,  1, 32'h4,        1, 1, 32'h77,       32'hFFFFFFFC, 1);
    add(0, 0, 32'h0,        1, 0, 32'h0,        1,  0, 32'h0,        0, 0, 32'h0,        32'h0,        1);
    add(1, 0, 32'h0,        0, 0, 32'h0,        1,  1, 32'h0,        1, 0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h0,        1, 0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        1, 1, 32'h99,       1,  0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        0, 0, 32'h0,        1,  1, 32'h4,        1, 1, 32'h99,       32'h0,        1);

    foreach (vq[i]) begin
      @(negedge clk);
      rst_n          = vq[i].rst;
      redirect_valid = vq[i].rd;
      redirect_pc    = vq[i].rpc;
      mem_ready      = vq[i].mr;
      mem_rvalid     = vq[i].rv;
      mem_rdata      = vq[i].rdata;
      instr_ready    = vq[i].ir;
      #1;
      n_vec++;
      chk(i, "mem_valid", {31'b0, mem_valid}, {31'b0, vq[i].emv});
      chk(i, "instr_valid", {31'b0, instr_valid}, {31'b0, vq[i].eiv});
      if (vq[i].ca) chk(i, "mem_addr", mem_addr, vq[i].eaddr);
      if (vq[i].cd) begin
        chk(i, "instr", instr, vq[i].ei);
        chk(i, "instr_pc", instr_pc, vq[i].epc);
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
